// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR channel scheduler and the filter it feeds.
// Defaults here match the FIR_Filter build used by the beamformer front end.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_ACC_W  = 93;
    localparam int CH_W       = $clog2(DEF_NUM_CH);

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_tag_pipe.sv
// Delay line of {valid, channel} tags that shadows the filter pipeline.
// Exposes the next-to-last stage (result capture point) and the final stage.
module fir_tag_pipe
    import fir_sched_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_CW = CH_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [TAG_CW-1:0] in_ch,
    output logic              cap_valid,
    output logic [TAG_CW-1:0] cap_ch,
    output logic              out_valid,
    output logic [TAG_CW-1:0] out_ch
);

    logic [DEPTH-1:0]  valid_r;
    logic [TAG_CW-1:0] ch_r [DEPTH];

    // Shift tags one stage per clock; clearing drops every in-flight result.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ch_r[i] <= '0;
            end
        end else begin
            valid_r <= {valid_r[DEPTH-2:0], in_valid};
            ch_r[0] <= in_ch;
            for (int i = 1; i < DEPTH; i++) begin
                ch_r[i] <= ch_r[i-1];
            end
        end
    end

    assign cap_valid = valid_r[DEPTH-2];
    assign cap_ch    = ch_r[DEPTH-2];
    assign out_valid = valid_r[DEPTH-1];
    assign out_ch    = ch_r[DEPTH-1];

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexes one channel-indexed FIR datapath across NUM_CH channels:
// latches a frame on each sample tick, issues one channel per clock, re-tags results.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int FIR_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sample_tick,
    input  logic [NUM_CH*DATA_W-1:0]      ch_data,
    output logic                          fir_in_valid,
    output logic [ch_width(NUM_CH)-1:0]   fir_in_ch,
    output logic [DATA_W-1:0]             fir_data_in,
    input  logic [ACC_W-1:0]              fir_data_out,
    output logic                          out_valid,
    output logic [ch_width(NUM_CH)-1:0]   out_ch,
    output logic [ACC_W-1:0]              out_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int             CW       = ch_width(NUM_CH);
    localparam logic [CW-1:0]  LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [CW-1:0]  ONE_CH   = CW'(1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    sched_state_t      state_r;
    logic [DATA_W-1:0] hold_r [NUM_CH];
    logic              tick_s;
    logic              accept_s;
    logic              drop_s;
    logic [CW-1:0]     next_ch_s;
    logic              cap_valid_s;
    logic [CW-1:0]     cap_ch_s;

    assign tick_s    = sample_tick & en;
    assign accept_s  = tick_s & (state_r == IDLE);
    assign drop_s    = tick_s & (state_r != IDLE);
    assign next_ch_s = fir_in_ch + ONE_CH;

    // Frame sequencing: latch, issue channels in ascending order, then wait for the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            fir_in_valid <= 1'b0;
            fir_in_ch    <= '0;
            fir_data_in  <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_r[k] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            hold_r[k] <= ch_data[k*DATA_W +: DATA_W];
                        end
                        // Channel 0 goes out straight from the input bus, the rest from the holding regs.
                        fir_in_valid <= 1'b1;
                        fir_in_ch    <= '0;
                        fir_data_in  <= ch_data[DATA_W-1:0];
                        busy         <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fir_in_ch == LAST_CH) begin
                        fir_in_valid <= 1'b0;
                        state_r      <= DRAIN;
                    end else begin
                        fir_in_ch   <= next_ch_s;
                        fir_data_in <= hold_r[next_ch_s];
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        frame_done <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else if (cap_valid_s && (cap_ch_s == LAST_CH)) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + ONE_CNT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a dropped tick beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop_s) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Capture the filter result as its tag moves into the final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (cap_valid_s) begin
            out_data <= fir_data_out;
        end
    end

    fir_tag_pipe #(
        .DEPTH  (FIR_LATENCY + 1),
        .TAG_CW (CW)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (fir_in_valid),
        .in_ch     (fir_in_ch),
        .cap_valid (cap_valid_s),
        .cap_ch    (cap_ch_s),
        .out_valid (out_valid),
        .out_ch    (out_ch)
    );

endmodule
